// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one-at-a-time reads to instruction memory,
// buffers returned instructions with their PCs and presents them to decode.
module instruction_fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [7:0]      instruction,
    output logic [PC_W-1:0] ins_pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [1:0]      dbg_state
);

    // Memory side: imem_req/imem_addr are held from request start until the
    // cycle imem_ack=1; an ack while imem_req=0 is ignored. Decode side: an
    // entry moves when ins_valid & ins_ready, and the head is stable otherwise.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e           state_q;
    logic [PC_W-1:0]  fetch_pc_q;
    logic [PC_W-1:0]  addr_q;
    logic             req_q;

    logic [7:0]       ins_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             ack_acc;
    logic             push;
    logic             pop;
    logic             room;
    logic [CNT_W-1:0] count_next;
    logic [PC_W-1:0]  drop_target;

    always_comb begin
        ack_acc     = req_q & imem_ack;
        push        = ack_acc & (state_q == S_WAIT) & ~redirect;
        pop         = (count_q != '0) & ins_ready & ~redirect;
        count_next  = redirect ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
        // A request only starts when its eventual push already has a slot.
        room        = fetch_en & (count_next < CNT_W'(DEPTH));
        drop_target = redirect ? redirect_pc : fetch_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (fetch_en) begin
                            state_q <= S_WAIT;
                            req_q   <= 1'b1;
                            addr_q  <= redirect_pc;
                        end
                    end else if (room) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (!ack_acc) begin
                            state_q <= S_DROP;
                        end else if (fetch_en) begin
                            addr_q <= redirect_pc;
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end
                    end else if (ack_acc) begin
                        fetch_pc_q <= addr_q + PC_W'(1);
                        if (room) begin
                            addr_q <= addr_q + PC_W'(1);
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    // Wrong-path request still in flight; the latest redirect wins.
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (ack_acc) begin
                        if (fetch_en) begin
                            state_q <= S_WAIT;
                            addr_q  <= drop_target;
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]  <= addr_q;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign ins_valid   = (count_q != '0);
    assign instruction = ins_mem_q[rd_ptr_q];
    assign ins_pc      = pc_mem_q[rd_ptr_q];
    assign dbg_state   = state_q;

endmodule
